alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter DATA_W, default 32: operand and result width in bits; only 32 is required to be verified.
REQ-002 clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-003 rst_ni, input, 1: reset, synchronous, active-low.
REQ-004 src_a_i, input, DATA_W: operand A, unsigned/two's-complement bit vector.
REQ-005 src_b_i, input, DATA_W: operand B.
REQ-006 alu_control_i, input, 2: operation select; 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-007 alu_result_o, output, DATA_W: registered operation result.
REQ-008 alu_flags_o, output, 3: registered flags; [2] N (negative), [1] Z (zero), [0] C (carry/borrow).

Function
REQ-009 Latency SHALL be exactly one clock: inputs sampled at rising edge k appear on outputs after edge k and hold until edge k+1.
REQ-010 Outputs SHALL update every non-reset cycle; no enable or handshake exists.
REQ-011 ADD: result = (A + B) mod 2^DATA_W; C = carry out of bit DATA_W-1.
REQ-012 SUB: result = (A - B) mod 2^DATA_W; C = 1 iff A < B unsigned (borrow), so 10-5 gives C=0.
REQ-013 AND: result = A & B, bitwise; C = 0.
REQ-014 OR: result = A | B, bitwise; C = 0.
REQ-015 N SHALL equal result[DATA_W-1] for every operation.
REQ-016 Z SHALL be 1 iff result == 0, for every operation.
REQ-017 Flags SHALL be computed from the same-cycle result; no flag depends on prior operations.
REQ-018 Wrap-around: 0xFFFFFFFF + 1 gives result 0 with Z=1, C=1, N=0; 0 - 1 gives 0xFFFFFFFF with N=1, C=1, Z=0.
REQ-019 Changing alu_control_i or operands between edges SHALL not affect outputs until the next edge.

Reset
REQ-020 When rst_ni is low at a rising edge, alu_result_o SHALL become 0 and alu_flags_o SHALL become 3'b000.
REQ-021 Reset SHALL take priority over any operation sampled on the same edge.
REQ-022 The first edge with rst_ni high SHALL register the operation present on the inputs at that edge.
REQ-023 Reset asserted mid-stream SHALL discard the in-flight result; there is no recovery of it.
REQ-024 Z SHALL read 0 during reset; the flag register is cleared, not derived from the zero result.

Configuration
REQ-025 Macro ALU_OVF_FLAG_EN: when defined, for ADD and SUB flag bit [0] SHALL report signed two's-complement overflow instead of carry/borrow.
REQ-026 With ALU_OVF_FLAG_EN defined: ADD V = (A[msb]==B[msb]) && (R[msb]!=A[msb]); SUB V = (A[msb]!=B[msb]) && (R[msb]!=A[msb]); AND/OR bit [0] = 0.
REQ-027 Without ALU_OVF_FLAG_EN, bit [0] SHALL behave per REQ-011..REQ-014; the port list is identical in both builds.

Verification
REQ-028 Reset held low 2 cycles with A=10,B=5,op=00 -> result 0, flags 000; after release, the next edge gives result 15, flags 000.
REQ-029 A=10,B=5,op=01 -> result 5, flags 000; A=5,B=10,op=01 -> result 0xFFFFFFFB, flags 101.
REQ-030 A=5,B=3: op=10 -> result 1, flags 000; op=11 -> result 7, flags 000.
REQ-031 A=0xFFFFFFFF,B=1,op=00 -> result 0, flags 011; in the ALU_OVF_FLAG_EN build -> flags 010.
REQ-032 A=0x7FFFFFFF,B=1,op=00 -> result 0x80000000, flags 100 in the default build, 101 in the ALU_OVF_FLAG_EN build.
REQ-033 Back-to-back op changes every cycle (ADD, SUB, AND, OR): each result appears exactly one edge after its inputs; rst_ni pulsed low mid-sequence clears the outputs on that edge.

Source files
------------

// File: rtl/alu.sv
// Registered 2-bit-opcode ALU (ADD/SUB/AND/OR) with N/Z/C flags and one-cycle latency.
// Build option: define ALU_OVF_FLAG_EN to report signed overflow in flag bit [0] for ADD/SUB.
module alu #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  input  logic [1:0]        alu_control_i,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [2:0]        alu_flags_o
);

  localparam int unsigned MSB = DATA_W - 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // One extra bit on each arithmetic path captures carry-out / borrow.
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_result;
  logic              w_bit0;
  logic [2:0]        w_flags;

  logic [DATA_W-1:0] r_result;
  logic [2:0]        r_flags;

  assign w_sum  = {1'b0, src_a_i} + {1'b0, src_b_i};
  assign w_diff = {1'b0, src_a_i} - {1'b0, src_b_i};

  // Result mux and flag bit [0] selection.
  always_comb begin
    w_result = '0;
    w_bit0   = 1'b0;
    case (alu_control_i)
      OP_ADD: begin
        w_result = w_sum[DATA_W-1:0];
`ifdef ALU_OVF_FLAG_EN
        w_bit0 = (src_a_i[MSB] == src_b_i[MSB]) && (w_sum[MSB] != src_a_i[MSB]);
`else
        w_bit0 = w_sum[DATA_W];
`endif
      end
      OP_SUB: begin
        w_result = w_diff[DATA_W-1:0];
`ifdef ALU_OVF_FLAG_EN
        w_bit0 = (src_a_i[MSB] != src_b_i[MSB]) && (w_diff[MSB] != src_a_i[MSB]);
`else
        w_bit0 = w_diff[DATA_W];
`endif
      end
      OP_AND: w_result = src_a_i & src_b_i;
      OP_OR:  w_result = src_a_i | src_b_i;
      default: begin
        w_result = '0;
        w_bit0   = 1'b0;
      end
    endcase
  end

  assign w_flags = {w_result[MSB], (w_result == '0), w_bit0};

  // Reset clears the flag register outright, so Z reads 0 while in reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_result <= '0;
      r_flags  <= 3'b000;
    end else begin
      r_result <= w_result;
      r_flags  <= w_flags;
    end
  end

  assign alu_result_o = r_result;
  assign alu_flags_o  = r_flags;

endmodule

// File: tb/tb_alu.sv
// Directed, table-driven self-checking bench for alu (default or ALU_OVF_FLAG_EN build).
module tb_alu;

  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [1:0]        op;
  logic [DATA_W-1:0] result;
  logic [2:0]        flags;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp_r;
    logic [2:0]  exp_f;
  } vec_t;

  vec_t vecs[14];

  alu #(.DATA_W(DATA_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .src_a_i      (a),
    .src_b_i      (b),
    .alu_control_i(op),
    .alu_result_o (result),
    .alu_flags_o  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] exp_r, input logic [2:0] exp_f);
    checks++;
    if (result === exp_r && flags === exp_f) passes++;
    else $display("FAIL %s: got result=%h flags=%b, want result=%h flags=%b",
                  name, result, flags, exp_r, exp_f);
  endtask

  task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] vop);
    a  = va;
    b  = vb;
    op = vop;
  endtask

  // Advance one active edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] vop,
                              input logic [31:0] er, input logic [2:0] ef);
    vec_t v;
    v.a = va; v.b = vb; v.op = vop; v.exp_r = er; v.exp_f = ef;
    return v;
  endfunction

  initial begin
`ifdef ALU_OVF_FLAG_EN
    vecs[0]  = mk(32'd10,         32'd5,          2'b00, 32'd15,         3'b000);
    vecs[1]  = mk(32'd10,         32'd5,          2'b01, 32'd5,          3'b000);
    vecs[2]  = mk(32'd5,          32'd10,         2'b01, 32'hFFFF_FFFB,  3'b100);
    vecs[3]  = mk(32'd5,          32'd3,          2'b10, 32'd1,          3'b000);
    vecs[4]  = mk(32'd5,          32'd3,          2'b11, 32'd7,          3'b000);
    vecs[5]  = mk(32'hFFFF_FFFF,  32'd1,          2'b00, 32'd0,          3'b010);
    vecs[6]  = mk(32'h7FFF_FFFF,  32'd1,          2'b00, 32'h8000_0000,  3'b101);
    vecs[7]  = mk(32'd0,          32'd1,          2'b01, 32'hFFFF_FFFF,  3'b100);
    vecs[8]  = mk(32'hF0F0_F0F0,  32'h0F0F_0F0F,  2'b10, 32'd0,          3'b010);
    vecs[9]  = mk(32'hF0F0_F0F0,  32'h0F0F_0F0F,  2'b11, 32'hFFFF_FFFF,  3'b100);
    vecs[10] = mk(32'h8000_0000,  32'd1,          2'b01, 32'h7FFF_FFFF,  3'b001);
    vecs[11] = mk(32'h8000_0000,  32'h8000_0000,  2'b00, 32'd0,          3'b011);
    vecs[12] = mk(32'd5,          32'd5,          2'b01, 32'd0,          3'b010);
    vecs[13] = mk(32'hFFFF_FFFF,  32'hFFFF_FFFF,  2'b00, 32'hFFFF_FFFE,  3'b100);
`else
    vecs[0]  = mk(32'd10,         32'd5,          2'b00, 32'd15,         3'b000);
    vecs[1]  = mk(32'd10,         32'd5,          2'b01, 32'd5,          3'b000);
    vecs[2]  = mk(32'd5,          32'd10,         2'b01, 32'hFFFF_FFFB,  3'b101);
    vecs[3]  = mk(32'd5,          32'd3,          2'b10, 32'd1,          3'b000);
    vecs[4]  = mk(32'd5,          32'd3,          2'b11, 32'd7,          3'b000);
    vecs[5]  = mk(32'hFFFF_FFFF,  32'd1,          2'b00, 32'd0,          3'b011);
    vecs[6]  = mk(32'h7FFF_FFFF,  32'd1,          2'b00, 32'h8000_0000,  3'b100);
    vecs[7]  = mk(32'd0,          32'd1,          2'b01, 32'hFFFF_FFFF,  3'b101);
    vecs[8]  = mk(32'hF0F0_F0F0,  32'h0F0F_0F0F,  2'b10, 32'd0,          3'b010);
    vecs[9]  = mk(32'hF0F0_F0F0,  32'h0F0F_0F0F,  2'b11, 32'hFFFF_FFFF,  3'b100);
    vecs[10] = mk(32'h8000_0000,  32'd1,          2'b01, 32'h7FFF_FFFF,  3'b000);
    vecs[11] = mk(32'h8000_0000,  32'h8000_0000,  2'b00, 32'd0,          3'b011);
    vecs[12] = mk(32'd5,          32'd5,          2'b01, 32'd0,          3'b010);
    vecs[13] = mk(32'hFFFF_FFFF,  32'hFFFF_FFFF,  2'b00, 32'hFFFF_FFFE,  3'b101);
`endif

    // Reset held two edges with a live ADD on the inputs; Z must stay 0.
    rst_n = 1'b0;
    drive(32'd10, 32'd5, 2'b00);
    step();
    check("reset_edge1", 32'd0, 3'b000);
    step();
    check("reset_edge2", 32'd0, 3'b000);
    rst_n = 1'b1;
    step();
    check("first_after_reset", 32'd15, 3'b000);

    // Back-to-back vectors, one per edge.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].op);
      step();
      check($sformatf("vec%0d", i), vecs[i].exp_r, vecs[i].exp_f);
    end

    // Inputs changing between edges must not disturb the registered outputs.
    drive(32'd5, 32'd3, 2'b11);
    step();
    check("hold_before", 32'd7, 3'b000);
    drive(32'd0, 32'd0, 2'b00);
    #2;
    check("hold_mid_cycle", 32'd7, 3'b000);
    step();
    check("hold_next_edge", 32'd0, 3'b010);

    // ADD, SUB, AND, OR stream with a reset pulse in the middle.
    drive(32'd100, 32'd23, 2'b00);
    step();
    check("seq_add", 32'd123, 3'b000);
    drive(32'd100, 32'd23, 2'b01);
    rst_n = 1'b0;
    step();
    check("seq_reset_discard", 32'd0, 3'b000);
    rst_n = 1'b1;
    drive(32'hFF00_00FF, 32'h0F0F_0F0F, 2'b10);
    step();
    check("seq_and_after_reset", 32'h0F00_000F, 3'b000);
    drive(32'hFF00_00FF, 32'h0F0F_0F0F, 2'b11);
    step();
    check("seq_or", 32'hFF0F_0FFF, 3'b100);
    drive(32'd100, 32'd23, 2'b01);
    step();
    check("seq_sub", 32'd77, 3'b000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
